uart_tx_ctrl: RTL

//  Sequencer for the UART TX output mux: accepts a parallel frame, serialises it LSB-first,

---
 rtl/uart_tx_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// UART TX sequencer: latches a parallel frame, serialises it LSB-first and drives the TX mux select.
// Optional macro TWO_STOP_EN stretches STOP to two cycles; the default build uses a single stop bit.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [4:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // The state encoding is the mux select itself, so mux_sel comes straight off flops.
  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00000,
    ST_START  = 5'b00001,
    ST_DATA   = 5'b00011,
    ST_PARITY = 5'b00010,
    ST_STOP   = 5'b00110
  } state_t;

  state_t                  state, state_n;
  logic                    accept;
  logic                    stop_last;
  logic                    par_en_q;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   shreg;

`ifdef TWO_STOP_EN
  // Marks the second stop cycle; back-to-back acceptance is only allowed there.
  logic stop_cnt;

  always_ff @(posedge CLK) begin
    if (RST) stop_cnt <= 1'b0;
    else     stop_cnt <= (state == ST_STOP) && !stop_cnt;
  end

  assign stop_last = stop_cnt;
`else
  assign stop_last = 1'b1;
`endif

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (DATA_VALID) begin
          state_n = ST_START;
          accept  = 1'b1;
        end
      end
      ST_START:  state_n = ST_DATA;
      ST_DATA: begin
        if (bit_cnt == LAST_BIT) state_n = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: state_n = ST_STOP;
      ST_STOP: begin
        if (stop_last) begin
          if (DATA_VALID) begin
            state_n = ST_START;
            accept  = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default:   state_n = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n != ST_IDLE);

      // Frame fields are captured only on acceptance; later input changes are ignored.
      if (accept) begin
        shreg    <= P_DATA;
        par_en_q <= PAR_EN;
        par_bit  <= (^P_DATA) ^ PAR_TYP;
      end else if (state == ST_DATA) begin
        shreg    <= shreg >> 1;
      end

      if (state == ST_DATA && bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + CNT_W'(1);
      else                                         bit_cnt <= '0;
    end
  end

  assign mux_sel  = state;
  assign ser_data = shreg[0];

endmodule
